// File: rtl/output_requant_core.sv
// Requantizes a buffered beat of channel-summed partial sums into 8-bit output
// patches, streaming one core patch per accepted transfer.
module output_requant_core #(
  parameter int FMS_PATCH_SIZE = 8,
  parameter int VALID_CORE_NUM = 15,
  parameter int IN_WIDTH       = 20,
  parameter int OUT_WIDTH      = 8
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic                                                          clk_en,
  input  logic                                                          quant_mode,
  input  logic [4:0]                                                    shift_amt,
  input  logic                                                          infms_data_vld,
  input  logic [VALID_CORE_NUM*FMS_PATCH_SIZE*FMS_PATCH_SIZE*IN_WIDTH-1:0] infms_data,
  output logic                                                          in_ready,
  output logic                                                          out_vld,
  input  logic                                                          out_ready,
  output logic [FMS_PATCH_SIZE*FMS_PATCH_SIZE*OUT_WIDTH-1:0]            out_data,
  output logic [3:0]                                                    out_core_idx,
  output logic                                                          out_last,
  output logic                                                          drop_err
);

  localparam int LANES   = FMS_PATCH_SIZE * FMS_PATCH_SIZE;
  localparam int CORE_W  = LANES * IN_WIDTH;
  localparam int PATCH_W = LANES * OUT_WIDTH;
  localparam int BEAT_W  = VALID_CORE_NUM * CORE_W;
  localparam int EXT_W   = IN_WIDTH + 1;
  localparam logic [3:0] LAST_IDX = 4'(VALID_CORE_NUM - 1);
  localparam logic signed [EXT_W-1:0] INT8_MAX = EXT_W'(127);
  localparam logic signed [EXT_W-1:0] INT4_MAX = EXT_W'(7);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Round half up, arithmetic shift, ReLU, then clamp to the selected range.
  function automatic logic [OUT_WIDTH-1:0] requant_lane(
    input logic [IN_WIDTH-1:0] lane,
    input logic                mode,
    input logic [4:0]          sh
  );
    logic signed [EXT_W-1:0] ext_v;
    logic        [EXT_W-1:0] rnd_c;
    logic signed [EXT_W-1:0] shf_v;
    logic        [OUT_WIDTH-1:0] res;
    ext_v = {lane[IN_WIDTH-1], lane};
    if (sh != 5'd0) begin
      rnd_c = EXT_W'(1) << (sh - 5'd1);
    end else begin
      rnd_c = '0;
    end
    shf_v = (ext_v + $signed(rnd_c)) >>> sh;
    if (shf_v[EXT_W-1]) begin
      res = '0;
    end else if (mode) begin
      res = (shf_v > INT8_MAX) ? OUT_WIDTH'(INT8_MAX) : OUT_WIDTH'(shf_v);
    end else begin
      res = (shf_v > INT4_MAX) ? OUT_WIDTH'(INT4_MAX) : OUT_WIDTH'(shf_v);
    end
    return res;
  endfunction

  function automatic logic [PATCH_W-1:0] requant_core(
    input logic [CORE_W-1:0] core,
    input logic              mode,
    input logic [4:0]        sh
  );
    logic [PATCH_W-1:0] res;
    res = '0;
    for (int j = 0; j < LANES; j++) begin
      res[j*OUT_WIDTH +: OUT_WIDTH] = requant_lane(core[j*IN_WIDTH +: IN_WIDTH], mode, sh);
    end
    return res;
  endfunction

  state_t               state_r;
  logic [BEAT_W-1:0]    buffer_r;
  logic                 mode_r;
  logic [4:0]           shift_r;
  logic                 out_vld_r;
  logic [PATCH_W-1:0]   out_data_r;
  logic [3:0]           out_core_idx_r;
  logic                 out_last_r;
  logic                 drop_err_r;

  logic                 in_ready_s;
  logic                 capture_s;
  logic                 xfer_s;
  logic [4:0]           shift_in_s;
  logic [3:0]           next_sel_s;
  logic [PATCH_W-1:0]   first_patch_s;
  logic [PATCH_W-1:0]   next_patch_s;

  assign in_ready_s = (state_r == IDLE) || (out_vld_r && out_ready && out_last_r);
  assign capture_s  = clk_en && infms_data_vld && in_ready_s;
  assign xfer_s     = out_vld_r && out_ready;
  assign shift_in_s = (shift_amt > 5'd19) ? 5'd19 : shift_amt;

  // Core 0 is requantized straight from the input so it appears one cycle after capture.
  assign first_patch_s = requant_core(infms_data[CORE_W-1:0], quant_mode, shift_in_s);
  assign next_sel_s    = (out_core_idx_r == LAST_IDX) ? 4'd0 : out_core_idx_r + 4'd1;
  assign next_patch_s  = requant_core(buffer_r[int'(next_sel_s)*CORE_W +: CORE_W], mode_r, shift_r);

  // Beat capture, patch sequencing and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      buffer_r       <= '0;
      mode_r         <= 1'b0;
      shift_r        <= 5'd0;
      out_vld_r      <= 1'b0;
      out_data_r     <= '0;
      out_core_idx_r <= 4'd0;
      out_last_r     <= 1'b0;
      drop_err_r     <= 1'b0;
    end else if (clk_en) begin
      if (infms_data_vld && !in_ready_s) begin
        drop_err_r <= 1'b1;
      end
      if (capture_s) begin
        buffer_r       <= infms_data;
        mode_r         <= quant_mode;
        shift_r        <= shift_in_s;
        state_r        <= SEND;
        out_vld_r      <= 1'b1;
        out_data_r     <= first_patch_s;
        out_core_idx_r <= 4'd0;
        out_last_r     <= (LAST_IDX == 4'd0);
      end else if (xfer_s) begin
        if (out_last_r) begin
          state_r    <= IDLE;
          out_vld_r  <= 1'b0;
          out_last_r <= 1'b0;
        end else begin
          out_data_r     <= next_patch_s;
          out_core_idx_r <= next_sel_s;
          out_last_r     <= (next_sel_s == LAST_IDX);
        end
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_vld      = out_vld_r;
  assign out_data     = out_data_r;
  assign out_core_idx = out_core_idx_r;
  assign out_last     = out_last_r;
  assign drop_err     = drop_err_r;

endmodule

// File: tb/tb_output_requant_core.sv
// Randomized bench for output_requant_core against a queue-based patch model.
module tb_output_requant_core;

  localparam int CORES  = 15;
  localparam int LANES  = 64;
  localparam int BEAT_W = CORES * LANES * 20;
  localparam int PATCH_W = LANES * 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clk_en = 1'b0;
  logic               quant_mode = 1'b0;
  logic [4:0]         shift_amt = 5'd0;
  logic               infms_data_vld = 1'b0;
  logic [BEAT_W-1:0]  infms_data = '0;
  logic               in_ready;
  logic               out_vld;
  logic               out_ready = 1'b0;
  logic [PATCH_W-1:0] out_data;
  logic [3:0]         out_core_idx;
  logic               out_last;
  logic               drop_err;

  output_requant_core dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .quant_mode(quant_mode),
    .shift_amt(shift_amt), .infms_data_vld(infms_data_vld), .infms_data(infms_data),
    .in_ready(in_ready), .out_vld(out_vld), .out_ready(out_ready), .out_data(out_data),
    .out_core_idx(out_core_idx), .out_last(out_last), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PATCH_W-1:0] data;
    int                 idx;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_drop;
  int   lanes[CORES][LANES];
  bit   nxt_mode;
  int   nxt_shift;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Floor division form of "add half, shift right", then ReLU and clamp.
  function automatic int ref_lane(input int v, input bit mode, input int sh);
    int s, d, q, lim;
    s = (sh > 19) ? 19 : sh;
    d = 1 << s;
    if (s > 0) v = v + d / 2;
    if (v >= 0) q = v / d;
    else q = -((-v + d - 1) / d);
    lim = mode ? 127 : 7;
    if (q < 0) q = 0;
    if (q > lim) q = lim;
    return q;
  endfunction

  function automatic logic [PATCH_W-1:0] ref_patch(input int c, input bit mode, input int sh);
    logic [PATCH_W-1:0] p;
    int r;
    for (int j = 0; j < LANES; j++) begin
      r = ref_lane(lanes[c][j], mode, sh);
      p[j*8 +: 8] = r[7:0];
    end
    return p;
  endfunction

  function automatic logic [BEAT_W-1:0] pack_beat();
    logic [BEAT_W-1:0] b;
    int v;
    for (int c = 0; c < CORES; c++)
      for (int j = 0; j < LANES; j++) begin
        v = lanes[c][j];
        b[(c*LANES + j)*20 +: 20] = v[19:0];
      end
    return b;
  endfunction

  task automatic rand_beat();
    logic [19:0] r;
    for (int c = 0; c < CORES; c++)
      for (int j = 0; j < LANES; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = 20'($urandom);
          lanes[c][j] = int'($signed(r));
        end else begin
          lanes[c][j] = int'($urandom_range(0, 400)) - 200;
        end
      end
  endtask

  // One clock: check what the last edge produced, then drive and model the next edge.
  task automatic cycle(input bit rdy, input bit vld, input bit ce);
    bit exp_rdy;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check("out_vld", {511'd0, out_vld}, 512'd1);
      check("out_core_idx", {508'd0, out_core_idx}, 512'(exp_q[0].idx));
      check("out_last", {511'd0, out_last}, 512'(exp_q[0].idx == 14));
      check("out_data", out_data, exp_q[0].data);
    end else begin
      check("out_vld_idle", {511'd0, out_vld}, 512'd0);
    end
    check("drop_err", {511'd0, drop_err}, 512'(exp_drop));
    out_ready      = rdy;
    infms_data_vld = vld;
    clk_en         = ce;
    quant_mode     = nxt_mode;
    shift_amt      = 5'(nxt_shift);
    infms_data     = pack_beat();
    #1;
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
    check("in_ready", {511'd0, in_ready}, 512'(exp_rdy));
    if (ce) begin
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (vld) begin
        if (exp_rdy) begin
          for (int c = 0; c < CORES; c++) exp_q.push_back('{ref_patch(c, nxt_mode, nxt_shift), c});
        end else begin
          exp_drop = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    infms_data_vld = 1'b0;
    #1;
    check("rst_out_vld", {511'd0, out_vld}, 512'd0);
    check("rst_out_data", out_data, 512'd0);
    check("rst_out_idx", {508'd0, out_core_idx}, 512'd0);
    check("rst_out_last", {511'd0, out_last}, 512'd0);
    check("rst_drop_err", {511'd0, drop_err}, 512'd0);
    check("rst_in_ready", {511'd0, in_ready}, 512'd1);
    exp_q.delete();
    exp_drop = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Accept patches until the model is empty, scrambling mode/shift meanwhile.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      nxt_mode  = 1'($urandom);
      nxt_shift = $urandom_range(0, 31);
      cycle(1'b1, 1'b0, 1'b1);
      n++;
    end
    check("drain_timeout", 512'(exp_q.size()), 512'd0);
    cycle(1'b1, 1'b0, 1'b1);
  endtask

  task automatic start_beat(input bit mode, input int sh);
    nxt_mode  = mode;
    nxt_shift = sh;
    cycle(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    exp_drop = 1'b0;
    nxt_mode = 1'b1;
    nxt_shift = 0;
    rand_beat();
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);

    // Ramp: core c lanes = 16c+8, INT8 shift 4 -> c+1.
    for (int c = 0; c < CORES; c++)
      for (int j = 0; j < LANES; j++) lanes[c][j] = 16*c + 8;
    start_beat(1'b1, 4);
    drain(40);

    // ReLU and saturation, INT4 then INT8.
    for (int m = 0; m < 2; m++) begin
      rand_beat();
      for (int j = 0; j < LANES; j++) begin
        case (j % 4)
          0: lanes[0][j] = -5;
          1: lanes[0][j] = 3;
          2: lanes[0][j] = 7;
          default: lanes[0][j] = 100;
        endcase
      end
      lanes[0][63] = 524287;
      start_beat(1'(m), 0);
      drain(40);
    end

    // Rounding at shift 2, then shift 25 clamped to 19.
    rand_beat();
    for (int j = 0; j < LANES; j++) lanes[0][j] = (j % 3 == 0) ? 5 : ((j % 3 == 1) ? 6 : -6);
    start_beat(1'b1, 2);
    drain(40);
    for (int j = 0; j < LANES; j++) lanes[0][j] = 262144;
    start_beat(1'b1, 25);
    drain(40);

    // Backpressure on idx 3 with a dropped beat in the middle.
    rand_beat();
    start_beat(1'b0, 3);
    while (exp_q.size() > 12) cycle(1'b1, 1'b0, 1'b1);
    rand_beat();
    for (int k = 0; k < 5; k++) cycle(1'b0, (k == 2), 1'b1);
    drain(40);
    check("drop_sticky", {511'd0, drop_err}, 512'd1);
    do_reset();

    // Back-to-back: second beat coincides with idx-14 acceptance.
    rand_beat();
    start_beat(1'b1, 5);
    while (exp_q.size() > 1) cycle(1'b1, 1'b0, 1'b1);
    rand_beat();
    nxt_mode = 1'b0;
    nxt_shift = 1;
    cycle(1'b1, 1'b1, 1'b1);
    drain(40);

    // clk_en low for 3 cycles mid-beat, with an ignored pulse.
    rand_beat();
    start_beat(1'b1, 6);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, (k == 1), 1'b0);
    drain(40);

    // Reset at idx 7 aborts the beat.
    rand_beat();
    start_beat(1'b1, 3);
    while (exp_q.size() > 8) cycle(1'b1, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 1'b1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      bit vld;
      vld = ($urandom_range(0, 5) == 0);
      if (vld) rand_beat();
      nxt_mode  = 1'($urandom);
      nxt_shift = $urandom_range(0, 31);
      cycle(($urandom_range(0, 3) != 0), vld, ($urandom_range(0, 7) != 0));
      if (k == 300) do_reset();
    end
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
